// File: rtl/uart_word_rx.sv
// UART 8N1 receiver that assembles little-endian 32-bit words (or single bytes), holding each result until the next start bit.
// Latency: stop-bit sample to data_end/frame_err is one cycle; no backpressure, the consumer must sample data_out before the next word completes.
module uart_word_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        one_byte,
    output logic [31:0] data_out,
    output logic        data_end,
    output logic        frame_err
);
    localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TW       = $clog2(TO_LIMIT + 1);

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rxs_q;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [31:0]   word_q, word_d;
    logic          mode_q, mode_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [31:0]   data_out_q, data_out_d;
    logic          data_end_q, data_end_d;
    logic          frame_err_q, frame_err_d;

    // Idle-high reset values keep a reset from looking like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            mode_q      <= 1'b0;
            to_cnt_q    <= '0;
            data_out_q  <= '0;
            data_end_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            mode_q      <= mode_d;
            to_cnt_q    <= to_cnt_d;
            data_out_q  <= data_out_d;
            data_end_q  <= data_end_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        word_d      = word_q;
        mode_d      = mode_q;
        to_cnt_d    = to_cnt_q;
        data_out_d  = data_out_q;
        data_end_d  = data_end_q;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d    = S_START;
                    clk_cnt_d  = '0;
                    data_end_d = 1'b0;
                    to_cnt_d   = '0;
                    // Word format is fixed by the mode seen at its first byte.
                    if (byte_idx_q == 2'd0) begin
                        mode_d = one_byte;
                    end
                end else if (byte_idx_q != 2'd0) begin
                    if (to_cnt_q == TO_LAST) begin
                        byte_idx_d = '0;
                        word_d     = '0;
                        to_cnt_d   = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else begin
                    to_cnt_d = '0;
                end
            end

            S_START: begin
                if (clk_cnt_q == HALF_BIT) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rxs_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    if (rxs_q) begin
                        if (mode_q || byte_idx_q == 2'd3) begin
                            data_out_d = mode_q ? {24'h0, shift_q} : {shift_q, word_q[23:0]};
                            data_end_d = 1'b1;
                            byte_idx_d = '0;
                            word_d     = '0;
                        end else begin
                            word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        byte_idx_d  = '0;
                        word_d      = '0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out  = data_out_q;
    assign data_end  = data_end_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: directed cases plus random frames against a byte-queue reference model.
// Expected completions/errors are queued at stimulus time and matched by an independent monitor.
module tb_uart_word_rx;
    localparam int CPB    = 8;
    localparam int TOB    = 4;
    localparam int TO_CYC = CPB * TOB;
    // Start drive to stop sample: 2 sync flops + detect + half bit + 9 full bits.
    localparam int STOP_OFS = 3 + (CPB - 1) / 2 + 1 + 9 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        one_byte;
    logic [31:0] data_out;
    logic        data_end;
    logic        frame_err;

    uart_word_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .one_byte (one_byte),
        .data_out (data_out),
        .data_end (data_end),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [31:0] word;
        int          cyc;
    } ev_t;

    ev_t      exp_q[$];
    bit [7:0] part_q[$];
    bit       model_mode;
    int       checks = 0;
    int       fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: bytes accumulate in a queue; a word is the first four bytes, first byte lowest.
    task automatic model_frame(input bit [7:0] b, input bit ok, input bit ob, input int stop_cyc);
        ev_t         e;
        logic [31:0] w;
        if (part_q.size() == 0) model_mode = ob;
        e.cyc = stop_cyc;
        if (!ok) begin
            part_q.delete();
            e.is_err = 1'b1;
            e.word   = '0;
            exp_q.push_back(e);
        end else begin
            part_q.push_back(b);
            if (model_mode || part_q.size() == 4) begin
                w = '0;
                foreach (part_q[i]) w = w | (32'(part_q[i]) << (8 * i));
                e.is_err = 1'b0;
                e.word   = w;
                exp_q.push_back(e);
                part_q.delete();
            end
        end
    endtask

    task automatic send_frame(input bit [7:0] b, input bit ok, input bit ob, input int gap);
        logic [9:0] bits;
        bits = {ok, b, 1'b0};
        @(posedge clk);
        #1;
        one_byte = ob;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == 0) model_frame(b, ok, ob, cyc + STOP_OFS);
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        if (gap > 0) repeat (gap) @(posedge clk);
        if (gap >= TO_CYC) part_q.delete();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each completion or frame error.
    logic [31:0] prev_do = '0;
    logic        prev_de = 1'b0;
    logic        prev_fe = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (data_out !== prev_do) begin
                checks++;
                if (!(data_end && !prev_de)) begin
                    fails++;
                    $display("FAIL data_out_hold: changed 0x%08h -> 0x%08h with no completion", prev_do, data_out);
                end
            end
            if (data_end && !prev_de) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_word: got data_out=0x%08h, expected no completion", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_word", 32'(e.is_err), 32'd0);
                    if (!e.is_err) chk("word_value", data_out, e.word);
                    chk("word_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (frame_err) begin
                if (prev_fe) begin
                    checks++;
                    fails++;
                    $display("FAIL frame_err_width: got pulse longer than 1 cycle, expected 1");
                end else if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_frame_err: got frame_err=1, expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_err", 32'(e.is_err), 32'd1);
                    chk("err_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
        prev_do = data_out;
        prev_de = data_end;
        prev_fe = frame_err;
    end

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] rb;
        bit       rok;
        int       rgap;

        reset    = 1'b1;
        rx       = 1'b1;
        one_byte = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_data_out", data_out, 32'h0);
        chk("reset_data_end", 32'(data_end), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);

        // Single byte, then hold until the next start bit.
        send_frame(8'h02, 1'b1, 1'b1, 0);
        drain("single_drain");
        chk("single_data_out", data_out, 32'h0000_0002);
        repeat (20) @(negedge clk);
        chk("single_hold_data_end", 32'(data_end), 32'd1);

        // Full word with one_byte toggled after the first byte.
        fork
            send_frame(8'h13, 1'b1, 1'b0, 0);
            begin
                @(posedge clk);
                repeat (3) @(negedge clk);
                chk("data_end_before_detect", 32'(data_end), 32'd1);
                @(negedge clk);
                chk("data_end_cleared_on_start", 32'(data_end), 32'd0);
            end
        join
        send_frame(8'h05, 1'b1, 1'b1, 0);
        send_frame(8'h00, 1'b1, 1'b1, 0);
        chk("word_partial_data_end", 32'(data_end), 32'd0);
        send_frame(8'h00, 1'b1, 1'b0, 0);
        drain("word_drain");
        chk("word_data_out", data_out, 32'h0000_0513);
        chk("word_data_end", 32'(data_end), 32'd1);

        // Framing error discards the partial word.
        send_frame(8'hAA, 1'b1, 1'b0, 0);
        send_frame(8'h55, 1'b0, 1'b0, 12);
        drain("ferr_drain");
        chk("ferr_data_end", 32'(data_end), 32'd0);
        chk("ferr_data_out", data_out, 32'h0000_0513);
        send_frame(8'h78, 1'b1, 1'b0, 0);
        send_frame(8'h56, 1'b1, 1'b0, 0);
        send_frame(8'h34, 1'b1, 1'b0, 0);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        drain("after_ferr_drain");
        chk("after_ferr_data_out", data_out, 32'h1234_5678);

        // Two-cycle glitch.
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_data_end", 32'(data_end), 32'd0);
        chk("glitch_frame_err", 32'(frame_err), 32'd0);
        chk("glitch_data_out", data_out, 32'h1234_5678);
        send_frame(8'h01, 1'b1, 1'b1, 0);
        drain("glitch_drain");
        chk("glitch_next_data_out", data_out, 32'h0000_0001);

        // Inter-byte timeout.
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 40);
        send_frame(8'hEF, 1'b1, 1'b0, 0);
        send_frame(8'hBE, 1'b1, 1'b0, 0);
        send_frame(8'hAD, 1'b1, 1'b0, 0);
        send_frame(8'hDE, 1'b1, 1'b0, 0);
        drain("timeout_drain");
        chk("timeout_data_out", data_out, 32'hDEAD_BEEF);

        // Reset during data bit 3.
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (CPB * 4 + CPB / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        part_q.delete();
        @(negedge clk);
        chk("midreset_data_out", data_out, 32'h0);
        chk("midreset_data_end", 32'(data_end), 32'd0);
        repeat (20) @(posedge clk);
        send_frame(8'h7F, 1'b1, 1'b1, 0);
        drain("midreset_drain");
        chk("midreset_next_data_out", data_out, 32'h0000_007F);

        // Random frames: mixed modes, occasional bad stop bits and timeouts.
        for (int n = 0; n < 150; n++) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) rgap = $urandom_range(45, 70);
            else if (!rok) rgap = $urandom_range(12, 20);
            else rgap = $urandom_range(0, 6);
            send_frame(rb, rok, 1'($urandom_range(0, 1)), rgap);
        end
        repeat (50) @(posedge clk);
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
